accum_rd_ctrl: RTL and testbench

ACCUM_RD_CTRL -- requirements
Module: accum_rd_ctrl

---
 rtl/accum_rd_ctrl_pkg.sv | 16 +
 rtl/accum_delay_line.sv | 38 +++
 rtl/accum_rd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_accum_rd_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_rd_ctrl_pkg.sv
// Shared types for the accumulator read controller: FSM state encoding and
// the row-address type of the default accumulator geometry.
package accum_rd_ctrl_pkg;

    localparam int unsigned PKG_ACCUM_ROW  = 256;
    localparam int unsigned PKG_ADDR_WIDTH = $clog2(PKG_ACCUM_ROW);

    typedef logic [PKG_ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/accum_delay_line.sv
// Fixed-depth register pipeline with async clear; DEPTH=0 is a plain wire.
module accum_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_s;
            assign unused_clk_s = &{1'b0, clk, rstn};
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift register; every stage clears on reset so aborted data vanishes
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/accum_rd_ctrl.sv
// Accumulator read controller: issues one row per cycle down a diagonally
// skewed set of column reads and realigns the returned data into full rows.
module accum_rd_ctrl
    import accum_rd_ctrl_pkg::*;
#(
    parameter  int SYS_COL    = 16,
    parameter  int ACCUM_ROW  = 256,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         cmd_base_addr,
    input  logic [ADDR_WIDTH-1:0]         cmd_len,
    output logic [SYS_COL-1:0]            rd_en_out,
    output logic [ADDR_WIDTH-1:0]         rd_addr_out [0:SYS_COL-1],
    input  logic [DATA_WIDTH-1:0]         rd_data_in  [0:SYS_COL-1],
    output logic                          out_valid,
    output logic [SYS_COL*DATA_WIDTH-1:0] out_data,
    output logic                          out_last,
    output logic                          busy
);

    // Each skew lane carries {last_row, rd_en, rd_addr}
    localparam int LANE_W = ADDR_WIDTH + 2;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic                          cmd_ready_r;
    logic                          busy_r;
    logic [ADDR_WIDTH-1:0]         base_r;
    logic [ADDR_WIDTH-1:0]         len_r;
    logic [ADDR_WIDTH-1:0]         row_r;
    logic                          accept_s;
    logic                          issue_s;
    logic                          issue_last_s;
    logic [LANE_W-1:0]             lane0_r;
    logic [LANE_W-1:0]             lane_s    [SYS_COL];
    logic [DATA_WIDTH-1:0]         aligned_s [SYS_COL];
    logic [SYS_COL*DATA_WIDTH-1:0] aligned_flat_s;
    logic                          tail_en_r;
    logic                          tail_last_r;
    logic                          out_valid_r;
    logic                          out_last_r;
    logic [SYS_COL*DATA_WIDTH-1:0] out_data_r;

    // State register; ready/busy are registered decodes of the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state logic; DRAIN ends once the final row has been presented
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = accept_s     ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = issue_last_s ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_nxt_s = out_last_r   ? ST_IDLE  : ST_DRAIN;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = cmd_valid & cmd_ready_r;
            end
            ST_ISSUE: begin
                issue_s      = 1'b1;
                issue_last_s = (row_r == len_r);
            end
            ST_DRAIN: begin
                accept_s = 1'b0;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Command latch and row counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_r <= {ADDR_WIDTH{1'b0}};
            len_r  <= {ADDR_WIDTH{1'b0}};
            row_r  <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            base_r <= cmd_base_addr;
            len_r  <= cmd_len;
            row_r  <= {ADDR_WIDTH{1'b0}};
        end else if (issue_s) begin
            row_r  <= row_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Column-0 read request; the address wraps naturally at ADDR_WIDTH bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane0_r <= {LANE_W{1'b0}};
        end else begin
            lane0_r <= {issue_last_s, issue_s,
                        issue_s ? (base_r + row_r) : {ADDR_WIDTH{1'b0}}};
        end
    end

    assign lane_s[0] = lane0_r;

    genvar j;
    generate
        for (j = 1; j < SYS_COL; j++) begin : g_skew
            accum_delay_line #(.WIDTH(LANE_W), .DEPTH(1)) u_skew (
                .clk  (clk),
                .rstn (rstn),
                .din  (lane_s[j-1]),
                .dout (lane_s[j])
            );
        end

        for (j = 0; j < SYS_COL; j++) begin : g_col
            assign rd_en_out[j]   = lane_s[j][ADDR_WIDTH];
            assign rd_addr_out[j] = lane_s[j][ADDR_WIDTH-1:0];

            // Early columns wait longer so every column lands in the same cycle
            accum_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(SYS_COL-1-j)) u_deskew (
                .clk  (clk),
                .rstn (rstn),
                .din  (rd_data_in[j]),
                .dout (aligned_s[j])
            );
        end
    endgenerate

    // Row qualifier tracks the last column's request across the bank latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tail_en_r   <= 1'b0;
            tail_last_r <= 1'b0;
        end else begin
            tail_en_r   <= lane_s[SYS_COL-1][ADDR_WIDTH];
            tail_last_r <= lane_s[SYS_COL-1][ADDR_WIDTH+1];
        end
    end

    // Pack aligned columns into one row word
    always_comb begin
        aligned_flat_s = {(SYS_COL*DATA_WIDTH){1'b0}};
        for (int c = 0; c < SYS_COL; c++) begin
            aligned_flat_s[c*DATA_WIDTH +: DATA_WIDTH] = aligned_s[c];
        end
    end

    // Output row register; data holds between valid rows
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {(SYS_COL*DATA_WIDTH){1'b0}};
        end else begin
            out_valid_r <= tail_en_r;
            out_last_r  <= tail_en_r & tail_last_r;
            if (tail_en_r) begin
                out_data_r <= aligned_flat_s;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_accum_rd_ctrl.sv
// Randomized scoreboard bench for accum_rd_ctrl with a {col,addr} bank model.
module tb_accum_rd_ctrl;

    localparam int SC  = 4;
    localparam int AR  = 16;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int LAT = SC + 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base_addr;
    logic [AW-1:0]    cmd_len;
    logic [SC-1:0]    rd_en_out;
    logic [AW-1:0]    rd_addr_out [0:SC-1];
    logic [DW-1:0]    rd_data_in  [0:SC-1];
    logic             out_valid;
    logic [SC*DW-1:0] out_data;
    logic             out_last;
    logic             busy;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks_total = 0;
    int          checks_passed = 0;
    int          n_acc = 0;
    bit          act = 1'b0;
    bit          prev_rstn = 1'b0;
    int          acc_t = 0;
    int          ready_from = 1 << 30;
    int          m_base = 0;
    int          m_len = 0;
    logic [31:0] last_out = 32'h0;

    always #5 clk = ~clk;

    accum_rd_ctrl #(.SYS_COL(SC), .ACCUM_ROW(AR), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .rd_en_out     (rd_en_out),
        .rd_addr_out   (rd_addr_out),
        .rd_data_in    (rd_data_in),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    // Bank model: {col, addr} one cycle after a read, noise otherwise
    always @(posedge clk) begin
        for (int j = 0; j < SC; j++) begin
            rd_data_in[j] <= rd_en_out[j] ? {4'(j), rd_addr_out[j]} : 8'($urandom);
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks_total++;
        if (act_v === exp_v) checks_passed++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
    endtask

    function automatic logic [31:0] row_word(input int b, input int k);
        logic [31:0] d;
        d = 32'h0;
        for (int j = 0; j < SC; j++) d[j*8 +: 8] = {4'(j), 4'((b + k) % AR)};
        return d;
    endfunction

    // Reference model and monitor, evaluated mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            check("rst_ready", cmd_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rd_en", rd_en_out, 0);
            for (int j = 0; j < SC; j++) check($sformatf("rst_addr%0d", j), rd_addr_out[j], 0);
            check("rst_valid", out_valid, 0);
            check("rst_last", out_last, 0);
            check("rst_data", out_data, 0);
            act = 1'b0;
            sb_q.delete();
            last_out = 32'h0;
            ready_from = 1 << 30;
            prev_rstn = 1'b0;
        end else begin
            bit exp_busy;
            bit exp_ready;
            logic [SC-1:0] exp_en;
            if (!prev_rstn) ready_from = cyc + 1;
            prev_rstn = 1'b1;
            exp_busy  = act && (cyc >= acc_t) && (cyc <= acc_t + LAT + m_len);
            exp_ready = (cyc >= ready_from) && !exp_busy;
            check("busy", busy, exp_busy);
            check("cmd_ready", cmd_ready, exp_ready);

            exp_en = '0;
            for (int j = 0; j < SC; j++) begin
                int k;
                k = cyc - acc_t - 1 - j;
                if (act && k >= 0 && k <= m_len) begin
                    exp_en[j] = 1'b1;
                    check($sformatf("rd_addr%0d", j), rd_addr_out[j], (m_base + k) % AR);
                end
            end
            check("rd_en", rd_en_out, exp_en);

            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    last_out = e.data;
                end
            end else begin
                check("idle_last", out_last, 0);
                check("hold_data", out_data, last_out);
            end

            if (exp_ready && cmd_valid) begin
                acc_t  = cyc + 1;
                m_base = int'(cmd_base_addr);
                m_len  = int'(cmd_len);
                act    = 1'b1;
                n_acc++;
                for (int k = 0; k <= m_len; k++) begin
                    exp_t e;
                    e.cyc  = acc_t + LAT + k;
                    e.data = row_word(m_base, k);
                    e.last = (k == m_len);
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int b, input int l, input bit hold);
        int n0;
        int guard;
        n0 = n_acc;
        guard = 0;
        cmd_valid     = 1'b1;
        cmd_base_addr = 4'(b);
        cmd_len       = 4'(l);
        while (n_acc == n0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept_timeout", n_acc != n0, 1);
        if (!hold) begin
            cmd_valid     = 1'b0;
            cmd_base_addr = 4'($urandom);
            cmd_len       = 4'($urandom);
        end
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_base_addr = 4'h0;
        cmd_len = 4'h0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(6);
        send(2, 3, 1'b0);
        idle(12);
        send(14, 3, 1'b0);
        idle(12);
        send(9, 0, 1'b1);
        send(5, 2, 1'b0);
        idle(12);
        send(6, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle(20);
        for (int i = 0; i < 10; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 5));
        end
        cmd_valid = 1'b0;
        idle(30);
        send(0, 15, 1'b1);
        send(3, 2, 1'b0);
        idle(40);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
